// File: rtl/weights_double_buffer.sv
// Ping-pong weight buffer with two banks.
// The writer fills one bank with a tile of OC0-wide weight words. The tile
// closes on wr_last, or automatically when the bank's last address is written.
// The reader consumes closed tiles in write order and releases each one when
// it is done, which hands that bank back to the writer.
module weights_double_buffer #(
    parameter int OC0      = 4,
    parameter int DEPTH    = 256,
    parameter int ADDR_WID = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [16*OC0-1:0]     wr_dat,
    input  logic                  wr_vld,
    input  logic                  wr_last,
    output logic                  wr_rdy,
    output logic                  rd_tile_vld,
    output logic [ADDR_WID:0]     rd_tile_len,
    input  logic                  rd_en,
    input  logic [ADDR_WID-1:0]   rd_addr,
    output logic [16*OC0-1:0]     rd_dat,
    output logic                  rd_dat_vld,
    input  logic                  rd_release
);

    localparam int                W         = 16 * OC0;
    localparam logic [ADDR_WID:0] LAST_ADDR = (ADDR_WID+1)'(DEPTH - 1);
    localparam logic [ADDR_WID:0] ADDR_ONE  = (ADDR_WID+1)'(1);

    logic [W-1:0]      mem [0:1][0:DEPTH-1];
    logic [1:0]        full;
    logic [1:0]        full_nxt;
    logic [ADDR_WID:0] len [0:1];
    logic              wbank;
    logic              rbank;
    logic [ADDR_WID:0] waddr;

    logic              wr_fire;
    logic              wr_close;
    logic              rel_fire;

    assign rd_tile_vld = full[rbank];
    assign rd_tile_len = len[rbank];

    // Handshake qualifiers: accept writes into a non-full bank, and close a tile on last or overflow.
    always_comb begin
        wr_rdy   = rst_n & ~full[wbank];
        wr_fire  = wr_vld & wr_rdy;
        wr_close = wr_fire & (wr_last | (waddr == LAST_ADDR));
        rel_fire = rd_release & full[rbank];
    end

    // Next full flags. A close and a release never hit the same bank, because
    // a write needs the bank empty and a release needs it full. Both can
    // therefore be applied in the same cycle.
    always_comb begin
        full_nxt = full;
        if (rel_fire) begin
            full_nxt[rbank] = 1'b0;
        end
        if (wr_close) begin
            full_nxt[wbank] = 1'b1;
        end
    end

    // Bank storage. This is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wbank][waddr[ADDR_WID-1:0]] <= wr_dat;
        end
    end

    // Write pointer, per-bank tile state and read bank selection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full   <= '0;
            wbank  <= 1'b0;
            rbank  <= 1'b0;
            waddr  <= '0;
            len[0] <= '0;
            len[1] <= '0;
        end else begin
            full <= full_nxt;
            if (wr_fire) begin
                if (wr_close) begin
                    len[wbank] <= waddr + ADDR_ONE;
                    wbank      <= ~wbank;
                    waddr      <= '0;
                end else begin
                    waddr <= waddr + ADDR_ONE;
                end
            end
            if (rel_fire) begin
                rbank <= ~rbank;
            end
        end
    end

    // Registered read port. A read issued together with a release is served
    // from the bank being released.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_dat     <= '0;
            rd_dat_vld <= 1'b0;
        end else if (rd_en && full[rbank]) begin
            rd_dat     <= mem[rbank][rd_addr];
            rd_dat_vld <= 1'b1;
        end else begin
            rd_dat_vld <= 1'b0;
        end
    end

endmodule
